// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared FSM encoding, divider rate-select codes and the
// count thresholds used to recommend a select code for a measured frequency.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } fm_state_t;

    // Divider rate-select codes, named by the sample rate they produce (Hz)
    localparam logic [3:0] SEL_100  = 4'd0;
    localparam logic [3:0] SEL_500  = 4'd1;
    localparam logic [3:0] SEL_1K   = 4'd2;
    localparam logic [3:0] SEL_5K   = 4'd3;
    localparam logic [3:0] SEL_10K  = 4'd4;
    localparam logic [3:0] SEL_50K  = 4'd5;
    localparam logic [3:0] SEL_100K = 4'd6;
    localparam logic [3:0] SEL_200K = 4'd7;
    localparam logic [3:0] SEL_500K = 4'd8;
    localparam logic [3:0] SEL_1M   = 4'd9;
    localparam logic [3:0] SEL_2M   = 4'd10;
    localparam logic [3:0] SEL_5M   = 4'd11;
    localparam logic [3:0] SEL_10M  = 4'd12;
    localparam logic [3:0] SEL_25M  = 4'd13;
    localparam logic [3:0] SEL_MAX  = 4'd14;

    localparam int SEL_N_THRESH = 14;

    // Largest count that code i can still sample at 10x or better
    localparam logic [31:0] SEL_THRESH [SEL_N_THRESH] = '{
        32'd10,     32'd50,     32'd100,     32'd500,
        32'd1000,   32'd5000,   32'd10000,   32'd20000,
        32'd50000,  32'd100000, 32'd200000,  32'd500000,
        32'd1000000, 32'd2500000
    };

    // Smallest select code whose threshold covers the count; a saturated
    // window cannot be trusted, so it always asks for the fastest rate.
    function automatic logic [3:0] sel_map(input logic [31:0] count,
                                           input logic        ovf);
        logic [3:0] code;
        code = SEL_MAX;
        for (int i = SEL_N_THRESH - 1; i >= 0; i--) begin
            if (count <= SEL_THRESH[i]) code = 4'(i);
        end
        if (ovf) code = SEL_MAX;
        return code;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// sig_sync_edge: brings the asynchronous measured signal into the clk_50M
// domain and produces a one-cycle pulse per rising edge.
module sig_sync_edge (
    input  logic clk_50M,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic dly_p2;

    // Two-flop synchronizer followed by one delay flop for edge detection
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            dly_p2  <= 1'b0;
        end else begin
            sync_p0 <= sig_in;
            sync_p1 <= sync_p0;
            dly_p2  <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~dly_p2;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated-window frequency counter. Counts rising edges of sig_in
// over GATE_CYCLES clocks, publishes the count, an overflow flag and a
// recommended divider select code once per completed window.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 27
) (
    input  logic             clk_50M,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             en,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic [3:0]       sel_rec,
    output logic             busy
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    fm_state_t         state;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              ovf_flag;
    logic              rise;

    // Edge counter sticks at full scale instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

    sig_sync_edge u_sync (
        .clk_50M (clk_50M),
        .rst     (rst),
        .sig_in  (sig_in),
        .rise    (rise)
    );

    // Window FSM: IDLE waits for en, GATE counts edges, DONE publishes results
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf_flag   <= 1'b0;
            freq       <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
            sel_rec    <= SEL_100;
            busy       <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_flag <= 1'b0;
                        state    <= GATE;
                        busy     <= 1'b1;
                    end
                end
                GATE: begin
                    if (!en) begin
                        // Truncated window: drop it, published outputs untouched
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        if (rise) begin
                            if (edge_cnt == CNT_MAX) ovf_flag <= 1'b1;
                            edge_cnt <= sat_inc(edge_cnt);
                        end
                        if (gate_cnt == GATE_LAST) state <= DONE;
                    end
                end
                DONE: begin
                    // One dead cycle: edges here are not counted
                    freq       <= edge_cnt;
                    overflow   <= ovf_flag;
                    sel_rec    <= sel_map(32'(edge_cnt), ovf_flag);
                    freq_valid <= 1'b1;
                    gate_cnt   <= '0;
                    edge_cnt   <= '0;
                    ovf_flag   <= 1'b0;
                    if (en) begin
                        state <= GATE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed sequence with randomized input waveforms, checked
// against an edge-history reference model of the gated window.
module tb_freq_meter;

    localparam int G   = 1000;
    localparam int CW  = 27;
    localparam int CWO = 4;
    localparam int LIM [14] = '{10, 50, 100, 500, 1000, 5000, 10000, 20000,
                                50000, 100000, 200000, 500000, 1000000, 2500000};

    logic clk_50M = 1'b0;
    logic rst     = 1'b1;
    logic sig_in  = 1'b0;
    logic en      = 1'b0;

    logic [CW-1:0]  freq;
    logic           freq_valid, overflow, busy;
    logic [3:0]     sel_rec;
    logic [CWO-1:0] freq_o;
    logic           freq_valid_o, overflow_o, busy_o;
    logic [3:0]     sel_rec_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit vhist [100000];
    int sig_mode    = 0;
    int hi_len      = 5;
    int lo_len      = 5;
    int sig_ph      = 0;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(CW)) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .sig_in     (sig_in),
        .en         (en),
        .freq       (freq),
        .freq_valid (freq_valid),
        .overflow   (overflow),
        .sel_rec    (sel_rec),
        .busy       (busy)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(CWO)) dut_o (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .sig_in     (sig_in),
        .en         (en),
        .freq       (freq_o),
        .freq_valid (freq_valid_o),
        .overflow   (overflow_o),
        .sel_rec    (sel_rec_o),
        .busy       (busy_o)
    );

    always #10 clk_50M = ~clk_50M;

    // Pin value seen at each clock edge; reset clears the synchronizer, so it reads as 0
    always @(posedge clk_50M) begin
        vhist[cyc] <= rst ? 1'b0 : sig_in;
        cyc <= cyc + 1;
    end

    // Input waveform: 0 = low, 1 = periodic hi_len/lo_len, 2 = random bit per cycle
    initial begin
        forever begin
            @(posedge clk_50M);
            #2;
            case (sig_mode)
                1: begin
                    sig_ph++;
                    if (sig_in ? (sig_ph >= hi_len) : (sig_ph >= lo_len)) begin
                        sig_in = ~sig_in;
                        sig_ph = 0;
                    end
                end
                2: sig_in = 1'($urandom);
                default: begin
                    sig_in = 1'b0;
                    sig_ph = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    // Rising edges whose counting edge falls inside the window opened at edge k0
    function automatic int model_raw(input int k0);
        int n;
        n = 0;
        for (int m = k0 + 1; m <= k0 + G; m++)
            if (vhist[m-2] && !vhist[m-3]) n++;
        return n;
    endfunction

    function automatic longint sat(input int raw, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (longint'(raw) > mx) ? mx : longint'(raw);
    endfunction

    function automatic logic [3:0] model_sel(input longint c, input bit ovf);
        if (ovf) return 4'd14;
        for (int i = 0; i < 14; i++)
            if (c <= longint'(LIM[i])) return 4'(i);
        return 4'd14;
    endfunction

    // Step through one window that opens at edge k0 and check its publication
    task automatic run_window(input int k0, input string tag, input bit drop_done);
        int     raw;
        longint e, eo;
        bit     ov, ovo;
        while (cyc < k0 + G + 2) begin
            tick();
            if (cyc < k0 + G + 2) begin
                chk({tag, "/in_window"}, {freq_valid, busy, freq_valid_o, busy_o}, 4'b0101);
                if (drop_done && cyc == k0 + G + 1) en = 1'b0;
            end
        end
        raw = model_raw(k0);
        e   = sat(raw, CW);
        ov  = (longint'(raw) > e);
        eo  = sat(raw, CWO);
        ovo = (longint'(raw) > eo);
        chk({tag, "/valid"},  {freq_valid, freq_valid_o}, 2'b11);
        chk({tag, "/busy"},   {busy, busy_o}, drop_done ? 2'b00 : 2'b11);
        chk({tag, "/freq"},   freq, e);
        chk({tag, "/ovf"},    overflow, ov);
        chk({tag, "/sel"},    sel_rec, model_sel(e, ov));
        chk({tag, "/freq_o"}, freq_o, eo);
        chk({tag, "/ovf_o"},  overflow_o, ovo);
        chk({tag, "/sel_o"},  sel_rec_o, model_sel(eo, ovo));
    endtask

    initial begin
        int k0;

        // Reset held with en high and the input toggling
        rst = 1'b1; en = 1'b1; sig_mode = 2;
        repeat (5) tick();
        chk("reset/outs",   {freq, freq_valid, overflow, sel_rec, busy}, 0);
        chk("reset/outs_o", {freq_o, freq_valid_o, overflow_o, sel_rec_o, busy_o}, 0);
        rst = 1'b0;
        k0  = cyc;
        chk("reset/busy_low", {busy, busy_o}, 2'b00);
        run_window(k0, "rand0", 1'b0);

        // Period 10 continuous: exactly 100 edges per window
        sig_mode = 1; hi_len = 5; lo_len = 5;
        run_window(cyc - 1, "p10_a", 1'b0);
        run_window(cyc - 1, "p10_b", 1'b0);
        chk("p10/freq", freq, 100);
        chk("p10/sel",  sel_rec, 2);
        chk("p10/ovf",  overflow, 0);
        run_window(cyc - 1, "p10_c", 1'b0);
        chk("p10/freq2", freq, 100);

        // Mapping boundary: 10 -> code 0, 11..12 -> code 1
        hi_len = 50; lo_len = 50;
        run_window(cyc - 1, "p100_a", 1'b0);
        run_window(cyc - 1, "p100_b", 1'b0);
        chk("p100/freq", freq, 10);
        chk("p100/sel",  sel_rec, 0);
        hi_len = 45; lo_len = 45;
        run_window(cyc - 1, "p90_a", 1'b0);
        run_window(cyc - 1, "p90_b", 1'b0);
        chk("p90/freq_range", (freq >= 11 && freq <= 12), 1);
        chk("p90/sel", sel_rec, 1);

        // Period 2: 500 edges saturates the 4-bit instance
        hi_len = 1; lo_len = 1;
        run_window(cyc - 1, "p2_a", 1'b0);
        run_window(cyc - 1, "p2_b", 1'b0);
        chk("p2/freq_o", freq_o, 15);
        chk("p2/ovf_o",  overflow_o, 1);
        chk("p2/sel_o",  sel_rec_o, 14);
        chk("p2/freq",   freq, 500);
        chk("p2/sel",    sel_rec, 3);

        // Abort mid-window after a completed 100-edge window
        hi_len = 5; lo_len = 5;
        run_window(cyc - 1, "ab_pre_a", 1'b0);
        run_window(cyc - 1, "ab_pre_b", 1'b0);
        repeat (500) tick();
        en = 1'b0;
        tick();
        chk("abort/busy",  {busy, busy_o}, 2'b00);
        chk("abort/valid", {freq_valid, freq_valid_o}, 2'b00);
        chk("abort/freq",  freq, 100);
        repeat (20) begin
            tick();
            chk("abort/hold", {freq_valid, busy, freq}, {2'b00, 27'd100});
        end
        en = 1'b1;
        k0 = cyc;
        run_window(k0, "reen", 1'b0);

        // Reset pulse at gate cycle 700
        sig_mode = 2;
        repeat (700) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst/outs",   {freq, freq_valid, overflow, sel_rec, busy}, 0);
        chk("mid_rst/outs_o", {freq_o, freq_valid_o, overflow_o, sel_rec_o, busy_o}, 0);
        rst = 1'b0;
        k0  = cyc;
        run_window(k0, "post_rst", 1'b0);

        // Random waveforms; the last window loses en during its dead cycle
        for (int w = 0; w < 4; w++) begin
            sig_mode = ($urandom_range(0, 1) == 0) ? 1 : 2;
            hi_len   = $urandom_range(1, 60);
            lo_len   = $urandom_range(1, 60);
            run_window(cyc - 1, "rnd", (w == 3));
        end
        repeat (5) begin
            tick();
            chk("idle/quiet", {freq_valid, busy, freq_valid_o, busy_o}, 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
